// File: rtl/sa_dma_sequencer_if.sv
// Register-bus and K/X/Y DMA descriptor/status bundle for sa_dma_sequencer.
// master = sequencer side, slave = register host plus DMA engines.
interface sa_dma_sequencer_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 20,
    parameter int TAG_WIDTH      = 8,
    parameter int AXIL_WIDTH     = 32
);
    logic                      reg_wen;
    logic                      reg_ren;
    logic [3:0]                reg_addr;
    logic [AXIL_WIDTH-1:0]     reg_wdata;
    logic [AXIL_WIDTH-1:0]     reg_rdata;

    logic [AXI_ADDR_WIDTH-1:0] k_desc_addr, x_desc_addr, y_desc_addr;
    logic [LEN_WIDTH-1:0]      k_desc_len,  x_desc_len,  y_desc_len;
    logic [TAG_WIDTH-1:0]      k_desc_tag,  x_desc_tag,  y_desc_tag;
    logic                      k_desc_valid, x_desc_valid, y_desc_valid;
    logic                      k_desc_ready, x_desc_ready, y_desc_ready;
    logic [TAG_WIDTH-1:0]      k_stat_tag,  x_stat_tag,  y_stat_tag;
    logic [3:0]                k_stat_error, x_stat_error, y_stat_error;
    logic                      k_stat_valid, x_stat_valid, y_stat_valid;

    modport master (
        input  reg_wen, reg_ren, reg_addr, reg_wdata,
        output reg_rdata,
        output k_desc_addr, x_desc_addr, y_desc_addr,
        output k_desc_len, x_desc_len, y_desc_len,
        output k_desc_tag, x_desc_tag, y_desc_tag,
        output k_desc_valid, x_desc_valid, y_desc_valid,
        input  k_desc_ready, x_desc_ready, y_desc_ready,
        input  k_stat_tag, x_stat_tag, y_stat_tag,
        input  k_stat_error, x_stat_error, y_stat_error,
        input  k_stat_valid, x_stat_valid, y_stat_valid
    );

    modport slave (
        output reg_wen, reg_ren, reg_addr, reg_wdata,
        input  reg_rdata,
        input  k_desc_addr, x_desc_addr, y_desc_addr,
        input  k_desc_len, x_desc_len, y_desc_len,
        input  k_desc_tag, x_desc_tag, y_desc_tag,
        input  k_desc_valid, x_desc_valid, y_desc_valid,
        output k_desc_ready, x_desc_ready, y_desc_ready,
        output k_stat_tag, x_stat_tag, y_stat_tag,
        output k_stat_error, x_stat_error, y_stat_error,
        output k_stat_valid, x_stat_valid, y_stat_valid
    );
endinterface

// File: rtl/sa_dma_sequencer.sv
// Issues Y, K, X DMA descriptors for one systolic-array job and gathers completions.
// Optional macro SA_SEQ_IRQ_EN enables the sticky done interrupt.
module sa_dma_sequencer #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 20,
    parameter int TAG_WIDTH      = 8,
    parameter int AXIL_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    sa_dma_sequencer_if.master   bus,
    output logic                 irq
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE_Y = 3'd1;
    localparam logic [2:0] S_ISSUE_K = 3'd2;
    localparam logic [2:0] S_ISSUE_X = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;

`ifdef SA_SEQ_IRQ_EN
    localparam logic IRQ_MASK = 1'b1;
`else
    localparam logic IRQ_MASK = 1'b0;
`endif

    logic [2:0]            state_reg;
    logic [TAG_WIDTH-1:0]  tag_reg;
    logic [2:0]            pending_reg;
    logic [2:0]            pending_next;
    logic                  done_reg;
    logic                  error_reg;
    logic [AXIL_WIDTH-1:0] rdata_reg;
    logic [AXIL_WIDTH-1:0] rd_word;
    logic [AXIL_WIDTH-1:0] status_word;

    // Channel bit order everywhere: 0 = K, 1 = X, 2 = Y.
    logic [2:0] stat_valid, stat_err, stat_tag_ok, stat_hit, desc_ready, len_zero;
    logic       busy, wr_ctrl, start, clr, zero_len, done_set, status_err_hit;

    assign busy        = (state_reg != S_IDLE);
    assign stat_valid  = {bus.y_stat_valid, bus.x_stat_valid, bus.k_stat_valid};
    assign stat_err    = {|bus.y_stat_error, |bus.x_stat_error, |bus.k_stat_error};
    assign stat_tag_ok = {bus.y_stat_tag == tag_reg, bus.x_stat_tag == tag_reg,
                          bus.k_stat_tag == tag_reg};
    assign desc_ready  = {bus.y_desc_ready, bus.x_desc_ready, bus.k_desc_ready};

    // Completions may land in any busy state, even before their descriptor is issued.
    assign stat_hit       = {3{busy}} & stat_valid & stat_tag_ok;
    assign pending_next   = pending_reg & ~stat_hit;
    assign status_err_hit = |(stat_hit & stat_err);

    assign wr_ctrl  = bus.reg_wen && (bus.reg_addr == 4'd0);
    assign start    = wr_ctrl && bus.reg_wdata[0];
    assign clr      = wr_ctrl && bus.reg_wdata[1];
    assign zero_len = |len_zero;
    assign done_set = ((state_reg == S_IDLE) && start && zero_len) ||
                      ((state_reg == S_WAIT) && (pending_next == 3'b000));

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : ch
            logic [AXI_ADDR_WIDTH-1:0] addr_reg;
            logic [LEN_WIDTH-1:0]      len_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    addr_reg <= '0;
                    len_reg  <= '0;
                end else if (bus.reg_wen && !busy) begin
                    if (bus.reg_addr == 4'(2 + 2 * gi))
                        addr_reg <= AXI_ADDR_WIDTH'(bus.reg_wdata);
                    if (bus.reg_addr == 4'(3 + 2 * gi))
                        len_reg <= LEN_WIDTH'(bus.reg_wdata);
                end
            end

            assign len_zero[gi] = (len_reg == '0);
        end
    endgenerate

    // Payload comes straight from the registers, which are frozen while busy.
    assign bus.k_desc_addr  = ch[0].addr_reg;
    assign bus.x_desc_addr  = ch[1].addr_reg;
    assign bus.y_desc_addr  = ch[2].addr_reg;
    assign bus.k_desc_len   = ch[0].len_reg;
    assign bus.x_desc_len   = ch[1].len_reg;
    assign bus.y_desc_len   = ch[2].len_reg;
    assign bus.k_desc_tag   = tag_reg;
    assign bus.x_desc_tag   = tag_reg;
    assign bus.y_desc_tag   = tag_reg;
    assign bus.k_desc_valid = (state_reg == S_ISSUE_K);
    assign bus.x_desc_valid = (state_reg == S_ISSUE_X);
    assign bus.y_desc_valid = (state_reg == S_ISSUE_Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            tag_reg     <= '0;
            pending_reg <= 3'b000;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (clr) begin
                done_reg  <= 1'b0;
                error_reg <= 1'b0;
            end
            if (status_err_hit)
                error_reg <= 1'b1;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        tag_reg   <= tag_reg + 1'b1;
                        done_reg  <= 1'b0;
                        error_reg <= 1'b0;
                        if (zero_len) begin
                            done_reg  <= 1'b1;
                            error_reg <= 1'b1;
                        end else begin
                            state_reg   <= S_ISSUE_Y;
                            pending_reg <= 3'b111;
                        end
                    end
                end
                S_ISSUE_Y: if (desc_ready[2]) state_reg <= S_ISSUE_K;
                S_ISSUE_K: if (desc_ready[0]) state_reg <= S_ISSUE_X;
                S_ISSUE_X: if (desc_ready[1]) state_reg <= S_WAIT;
                S_WAIT: begin
                    if (pending_next == 3'b000) begin
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef SA_SEQ_IRQ_EN
    logic irq_reg;

    // A done event in the same cycle as CLR wins so no completion is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq_reg <= 1'b0;
        else if (done_set)
            irq_reg <= 1'b1;
        else if (clr)
            irq_reg <= 1'b0;
    end
    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        status_word       = '0;
        status_word[0]    = busy;
        status_word[1]    = done_reg;
        status_word[2]    = error_reg;
        status_word[3]    = IRQ_MASK;
        status_word[15:8] = 8'(tag_reg);
    end

    always_comb begin
        rd_word = '0;
        case (bus.reg_addr)
            4'd1:    rd_word = status_word;
            4'd2:    rd_word = AXIL_WIDTH'(ch[0].addr_reg);
            4'd3:    rd_word = AXIL_WIDTH'(ch[0].len_reg);
            4'd4:    rd_word = AXIL_WIDTH'(ch[1].addr_reg);
            4'd5:    rd_word = AXIL_WIDTH'(ch[1].len_reg);
            4'd6:    rd_word = AXIL_WIDTH'(ch[2].addr_reg);
            4'd7:    rd_word = AXIL_WIDTH'(ch[2].len_reg);
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_reg <= '0;
        else if (bus.reg_ren)
            rdata_reg <= rd_word;
    end

    assign bus.reg_rdata = rdata_reg;
endmodule

// File: tb/tb_sa_dma_sequencer.sv
// Directed self-checking bench for sa_dma_sequencer: basic run, backpressure,
// early completion with error, stale tags, zero length and mid-run reset.
module tb_sa_dma_sequencer;
`ifdef SA_SEQ_IRQ_EN
    localparam logic [31:0] IRQB   = 32'h8;
    localparam logic        IRQ_EN = 1'b1;
`else
    localparam logic [31:0] IRQB   = 32'h0;
    localparam logic        IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] rv;

    sa_dma_sequencer_if #(.AXI_ADDR_WIDTH(32), .LEN_WIDTH(20), .TAG_WIDTH(8), .AXIL_WIDTH(32)) bus ();

    sa_dma_sequencer #(.AXI_ADDR_WIDTH(32), .LEN_WIDTH(20), .TAG_WIDTH(8), .AXIL_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        bus.reg_addr  = addr;
        bus.reg_wdata = data;
        bus.reg_wen   = 1'b1;
        tick();
        bus.reg_wen   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] addr, output logic [31:0] data);
        bus.reg_addr = addr;
        bus.reg_ren  = 1'b1;
        tick();
        bus.reg_ren  = 1'b0;
        data = bus.reg_rdata;
    endtask

    // mask bit0 = K, bit1 = X, bit2 = Y; kerr goes on the K error field
    task automatic stat(input logic [2:0] mask, input logic [7:0] tag, input logic [3:0] kerr);
        bus.k_stat_valid = mask[0];
        bus.x_stat_valid = mask[1];
        bus.y_stat_valid = mask[2];
        bus.k_stat_tag   = tag;
        bus.x_stat_tag   = tag;
        bus.y_stat_tag   = tag;
        bus.k_stat_error = kerr;
        tick();
        bus.k_stat_valid = 1'b0;
        bus.x_stat_valid = 1'b0;
        bus.y_stat_valid = 1'b0;
        bus.k_stat_error = 4'h0;
    endtask

    task automatic program_regs();
        wr(4'd2, 32'h1000); wr(4'd3, 32'd64);
        wr(4'd4, 32'h2000); wr(4'd5, 32'd128);
        wr(4'd6, 32'h3000); wr(4'd7, 32'd32);
    endtask

    initial begin
        rst = 1'b1;
        bus.reg_wen = 1'b0; bus.reg_ren = 1'b0; bus.reg_addr = 4'd0; bus.reg_wdata = 32'd0;
        bus.k_desc_ready = 1'b1; bus.x_desc_ready = 1'b1; bus.y_desc_ready = 1'b1;
        bus.k_stat_valid = 1'b0; bus.x_stat_valid = 1'b0; bus.y_stat_valid = 1'b0;
        bus.k_stat_tag = 8'd0; bus.x_stat_tag = 8'd0; bus.y_stat_tag = 8'd0;
        bus.k_stat_error = 4'h0; bus.x_stat_error = 4'h0; bus.y_stat_error = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_valids", {bus.y_desc_valid, bus.k_desc_valid, bus.x_desc_valid}, 3'b000);
        check("rst_payload", {bus.y_desc_addr, bus.k_desc_len, bus.x_desc_tag}, 64'd0);
        check("rst_rdata", bus.reg_rdata, 32'd0);
        check("rst_irq", irq, 1'b0);
        rd(4'd1, rv); check("rst_status", rv, IRQB);

        // Basic run: Y, K, X in N+1..N+3, tag 1
        program_regs();
        rd(4'd2, rv); check("rd_k_addr", rv, 32'h1000);
        rd(4'd8, rv); check("rd_unmapped", rv, 32'd0);
        wr(4'd0, 32'h1);
        check("n1_y", {bus.y_desc_valid, bus.k_desc_valid, bus.y_desc_addr, bus.y_desc_len, bus.y_desc_tag},
              {1'b1, 1'b0, 32'h3000, 20'd32, 8'd1});
        tick();
        check("n2_k", {bus.k_desc_valid, bus.x_desc_valid, bus.k_desc_addr, bus.k_desc_len, bus.k_desc_tag},
              {1'b1, 1'b0, 32'h1000, 20'd64, 8'd1});
        tick();
        check("n3_x", {bus.x_desc_valid, bus.k_desc_valid, bus.x_desc_addr, bus.x_desc_len, bus.x_desc_tag},
              {1'b1, 1'b0, 32'h2000, 20'd128, 8'd1});
        tick();
        check("n4_none", {bus.y_desc_valid, bus.k_desc_valid, bus.x_desc_valid}, 3'b000);
        rd(4'd1, rv); check("run1_busy", rv, 32'h101 | IRQB);

        // Stale tag, START while busy, register write while busy
        stat(3'b001, 8'd0, 4'h0);
        rd(4'd1, rv); check("stale_ignored", rv, 32'h101 | IRQB);
        wr(4'd0, 32'h1);
        wr(4'd2, 32'hdead);
        rd(4'd1, rv); check("start_busy_tag", rv, 32'h101 | IRQB);

        // K and X together, then Y completes the run
        stat(3'b011, 8'd1, 4'h0);
        rd(4'd1, rv); check("kx_still_busy", rv, 32'h101 | IRQB);
        stat(3'b100, 8'd1, 4'h0);
        rd(4'd1, rv); check("run1_done", rv, 32'h102 | IRQB);
        check("run1_irq", irq, IRQ_EN);
        rd(4'd2, rv); check("busy_write_ignored", rv, 32'h1000);
        wr(4'd0, 32'h2);
        rd(4'd1, rv); check("clr_status", rv, 32'h100 | IRQB);
        check("clr_irq", irq, 1'b0);

        // Backpressure on K, X held off for early completion
        bus.k_desc_ready = 1'b0;
        bus.x_desc_ready = 1'b0;
        wr(4'd0, 32'h1);
        check("run2_y", {bus.y_desc_valid, bus.y_desc_tag}, {1'b1, 8'd2});
        tick();
        for (int i = 0; i < 10; i++) begin
            check("k_hold", {bus.k_desc_valid, bus.k_desc_addr, bus.k_desc_len, bus.x_desc_valid},
                  {1'b1, 32'h1000, 20'd64, 1'b0});
            tick();
        end
        bus.k_desc_ready = 1'b1;
        tick();
        check("x_after_k", {bus.x_desc_valid, bus.k_desc_valid}, 2'b10);
        stat(3'b101, 8'd2, 4'h2);
        check("x_held", bus.x_desc_valid, 1'b1);
        rd(4'd1, rv); check("early_err_busy", rv, 32'h205 | IRQB);
        bus.x_desc_ready = 1'b1;
        tick();
        check("x_released", bus.x_desc_valid, 1'b0);
        stat(3'b010, 8'd2, 4'h0);
        rd(4'd1, rv); check("run2_done_err", rv, 32'h206 | IRQB);
        check("run2_irq", irq, IRQ_EN);
        wr(4'd0, 32'h2);

        // Zero length on X
        wr(4'd5, 32'd0);
        wr(4'd0, 32'h1);
        check("zl_no_desc_a", {bus.y_desc_valid, bus.k_desc_valid, bus.x_desc_valid}, 3'b000);
        rd(4'd1, rv); check("zl_status", rv, 32'h306 | IRQB);
        check("zl_no_desc_b", {bus.y_desc_valid, bus.k_desc_valid, bus.x_desc_valid}, 3'b000);
        check("zl_irq", irq, IRQ_EN);

        // Reset in WAIT, then a fresh run starts at tag 1
        wr(4'd5, 32'd128);
        wr(4'd0, 32'h3);
        check("run4_tag", {bus.y_desc_valid, bus.y_desc_tag}, {1'b1, 8'd4});
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {bus.y_desc_valid, bus.k_desc_valid, bus.x_desc_valid, irq}, 4'b0000);
        tick(); tick();
        rst = 1'b0;
        rd(4'd5, rv); check("rst_x_len", rv, 32'd0);
        rd(4'd1, rv); check("rst_status2", rv, IRQB);
        program_regs();
        wr(4'd0, 32'h1);
        check("restart_tag", {bus.y_desc_valid, bus.y_desc_tag}, {1'b1, 8'd1});
        repeat (3) tick();
        stat(3'b111, 8'd0, 4'h0);
        rd(4'd1, rv); check("late_stale", rv, 32'h101 | IRQB);
        stat(3'b111, 8'd1, 4'h0);
        rd(4'd1, rv); check("restart_done", rv, 32'h102 | IRQB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
